// File: rtl/key_event_fifo_if.sv
// Key event stream from key_event_fifo to its consumer.
// The FIFO is the master: it drives code, release and valid; the consumer drives ready.
interface key_event_fifo_if;
  logic [3:0] key_code;
  logic       key_release;
  logic       key_valid;
  logic       key_ready;

  modport master (output key_code, output key_release, output key_valid, input key_ready);
  modport slave  (input key_code, input key_release, input key_valid, output key_ready);
endinterface

// File: rtl/key_event_fifo.sv
// Keypad bitmap -> debounced press events -> first-word-fall-through event FIFO.
// Define KEY_RELEASE_EN to also queue release events; entries then carry a release flag.
module key_event_fifo #(
  parameter int DEBOUNCE_N = 4,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic [15:0]              keys,
  input  logic                     clr,
  key_event_fifo_if.master         kif,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int CW = $clog2(DEBOUNCE_N) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_N - 1);
`ifdef KEY_RELEASE_EN
  localparam int EW = 5;
`else
  localparam int EW = 4;
`endif

  logic [15:0]   samp, stable, stable_d;
  logic [CW-1:0] cnt;
  logic [15:0]   press_edge, pend_p, clr_p;
  logic          any_pend, push, pop, full, sel_rel;
  logic [3:0]    sel_idx;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head, last, wdata;
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [3:0] lowest(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  // stable_d lags stable by one cycle, so stable & ~stable_d is the edge of the update
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      samp     <= '0;
      cnt      <= '0;
      stable   <= '0;
      stable_d <= '0;
    end else begin
      samp     <= keys;
      stable_d <= stable;
      if (keys != samp)     cnt <= '0;
      else if (cnt != CMAX) cnt <= cnt + CW'(1);
      if (keys == samp && cnt == CMAX) stable <= samp;
    end
  end

  assign press_edge = stable & ~stable_d;
  assign full = (count == (PW+1)'(DEPTH));
  assign pop  = kif.key_valid && kif.key_ready;

`ifdef KEY_RELEASE_EN
  logic [15:0] rel_edge, pend_r, clr_r;
  assign rel_edge = stable_d & ~stable;
  assign any_pend = (pend_p != '0) || (pend_r != '0);
  // every pending press drains before any pending release
  assign sel_rel  = (pend_p == '0);
  assign sel_idx  = sel_rel ? lowest(pend_r) : lowest(pend_p);
  assign clr_r    = (push && sel_rel) ? (16'd1 << sel_idx) : 16'd0;
  assign wdata    = {sel_rel, sel_idx};
`else
  assign any_pend = (pend_p != '0);
  assign sel_rel  = 1'b0;
  assign sel_idx  = lowest(pend_p);
  assign wdata    = sel_idx;
`endif
  assign push  = any_pend && (!full || pop);
  assign clr_p = (push && !sel_rel) ? (16'd1 << sel_idx) : 16'd0;

  // an edge only loses an event if its bit is still pending after this cycle's push
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pend_p   <= '0;
      overflow <= 1'b0;
`ifdef KEY_RELEASE_EN
      pend_r   <= '0;
`endif
    end else if (clr) begin
      pend_p   <= '0;
      overflow <= 1'b0;
`ifdef KEY_RELEASE_EN
      pend_r   <= '0;
`endif
    end else begin
      pend_p <= (pend_p & ~clr_p) | press_edge;
`ifdef KEY_RELEASE_EN
      pend_r   <= (pend_r & ~clr_r) | rel_edge;
      overflow <= overflow || ((press_edge & pend_p & ~clr_p) != '0)
                           || ((rel_edge & pend_r & ~clr_r) != '0);
`else
      overflow <= overflow || ((press_edge & pend_p & ~clr_p) != '0);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        last   <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // hold the last popped head while empty so outputs stay quiet
  assign kif.key_valid = (count != '0);
  assign head          = kif.key_valid ? mem[rd_ptr] : last;
  assign kif.key_code  = head[3:0];
`ifdef KEY_RELEASE_EN
  assign kif.key_release = head[4];
`else
  assign kif.key_release = 1'b0;
`endif
endmodule

// File: tb/tb_key_event_fifo.sv
// Scoreboard bench for key_event_fifo: expected events queued as keys change, checked at pop.
module tb_key_event_fifo;
  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [15:0] keys = '0;
  logic        clr = 1'b0;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] cur = '0;
  logic [4:0]  sb_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  key_event_fifo_if kif ();

  key_event_fifo #(.DEBOUNCE_N(4), .DEPTH(8)) dut (
    .clk(clk), .rst_l(rst_l), .keys(keys), .clr(clr),
    .kif(kif.master), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_keys(input logic [15:0] nk);
    logic [15:0] pr, rl;
    pr = nk & ~cur;
    rl = cur & ~nk;
    for (int i = 0; i < 16; i++) if (pr[i]) sb_q.push_back({1'b0, 4'(i)});
`ifdef KEY_RELEASE_EN
    for (int i = 0; i < 16; i++) if (rl[i]) sb_q.push_back({1'b1, 4'(i)});
`else
    if (rl != '0) ;
`endif
    cur  = nk;
    keys = nk;
  endtask

  always @(negedge clk) begin
    if (rst_l && kif.key_valid && kif.key_ready) begin
      if (sb_q.size() == 0) chk("unexpected_pop", {27'd0, kif.key_release, kif.key_code}, 32'h3f);
      else chk("pop_data", {27'd0, kif.key_release, kif.key_code}, {27'd0, sb_q.pop_front()});
    end
  end

  initial begin
    kif.key_ready = 1'b0;
    #12;
    chk("rst_valid", kif.key_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_code", kif.key_code, 0);
    @(posedge clk); #1;
    rst_l = 1'b1;
    cyc(2);

    // single press, then pop
    set_keys(16'h0001);
    cyc(10);
    chk("t1_count", count, 1);
    chk("t1_valid", kif.key_valid, 1);
    chk("t1_code", kif.key_code, 0);
    kif.key_ready = 1'b1;
    cyc(1);
    chk("t1_valid_after_pop", kif.key_valid, 0);
    set_keys(16'h0000);
    cyc(10);
    chk("t1_drained", count, 0);

    // short glitch must be filtered
    keys = 16'h0020;
    cyc(2);
    keys = 16'h0000;
    cyc(10);
    chk("t2_glitch_count", count, 0);

    // simultaneous presses emit in ascending order
    kif.key_ready = 1'b0;
    set_keys(16'h8041);
    cyc(10);
    chk("t3_count", count, 3);
    chk("t3_head", kif.key_code, 0);
    kif.key_ready = 1'b1;
    cyc(6);
    chk("t3_drained", count, 0);
    set_keys(16'h0000);
    cyc(12);
    chk("t3_rel_drained", count, 0);

    // fill beyond depth: ninth press waits in pending
    kif.key_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_keys(cur | (16'd1 << i));
      cyc(8);
    end
    chk("t4_full_count", count, 8);
    chk("t4_ovf", overflow, 0);
    kif.key_ready = 1'b1;
    cyc(1);
    kif.key_ready = 1'b0;
    chk("t4_push_pop_count", count, 8);
    cyc(3);
    chk("t4_count_hold", count, 8);
    chk("t4_head_after_pop", kif.key_code, 1);

    // re-press of a still-pending key loses an event
    set_keys(cur & ~16'h0008);
    cyc(8);
    set_keys(cur | 16'h0008);
    cyc(8);
    chk("t5_no_ovf_yet", overflow, 0);
    set_keys(cur & ~16'h0008);
    cyc(8);
    set_keys(cur | 16'h0008);
    cyc(8);
    chk("t5_ovf", overflow, 1);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    sb_q.delete();
    chk("t5_clr_count", count, 0);
    chk("t5_clr_ovf", overflow, 0);
    chk("t5_clr_valid", kif.key_valid, 0);
    kif.key_ready = 1'b1;
    cyc(10);
    chk("t5_no_reemit", count, 0);
    set_keys(16'h0000);
    cyc(14);
    chk("t5_rel_drained", count, 0);

    // reset in the middle of a queue
    kif.key_ready = 1'b0;
    set_keys(16'h0005);
    cyc(10);
    chk("t6_count", count, 2);
    chk("t6_head", kif.key_code, 0);
    rst_l = 1'b0;
    keys  = 16'h0000;
    cur   = 16'h0000;
    #1;
    chk("t6_rst_valid", kif.key_valid, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_code", kif.key_code, 0);
    chk("t6_rst_rel", kif.key_release, 0);
    chk("t6_rst_ovf", overflow, 0);
    sb_q.delete();
    cyc(2);
    rst_l = 1'b1;
    kif.key_ready = 1'b1;
    cyc(10);
    chk("t6_post_rst_count", count, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
